pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bundle: ID-stage decode fields and branch status in,
// forwarding selects, pipeline control and event counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDvalid;
  logic [4:0]       IDrs;
  logic [4:0]       IDrt;
  logic             IDuse_rs;
  logic             IDuse_rt;
  logic             IDwreg;
  logic             IDm2reg;
  logic [4:0]       IDwn;
  logic             EXbr_taken;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             stall;
  logic             flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IDvalid, IDrs, IDrt, IDuse_rs, IDuse_rt, IDwreg, IDm2reg, IDwn, EXbr_taken,
    input  fwda, fwdb, stall, flush, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  IDvalid, IDrs, IDrt, IDuse_rs, IDuse_rt, IDwreg, IDm2reg, IDwn, EXbr_taken,
    output fwda, fwdb, stall, flush, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use stall,
// taken-branch flush sequencing and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               clrn,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_FLUSH   = 2'b10
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] wn;
  } shadow_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_remaining, w_remaining_nxt;
  shadow_t          r_ex, r_mem;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_ex_src, w_mem_src, w_ld_use;
  logic             w_stall, w_flush, w_flush_entry;
  logic [1:0]       w_fwda, w_fwdb;

  // Register 0 is hard-wired, so a write to it is never a forwarding source.
  assign w_ex_src  = r_ex.valid  && r_ex.wreg  && (r_ex.wn  != 5'd0);
  assign w_mem_src = r_mem.valid && r_mem.wreg && (r_mem.wn != 5'd0);

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r);
    if (!use_r)                                   return 2'b00;
    if (w_ex_src && r_ex.wn == r && !r_ex.m2reg) return 2'b01;
    if (w_mem_src && r_mem.wn == r)              return r_mem.m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  assign w_fwda   = fwd_sel(bus.IDuse_rs, bus.IDrs);
  assign w_fwdb   = fwd_sel(bus.IDuse_rt, bus.IDrt);
  assign w_ld_use = bus.IDvalid && w_ex_src && r_ex.m2reg &&
                    ((bus.IDuse_rs && r_ex.wn == bus.IDrs) ||
                     (bus.IDuse_rt && r_ex.wn == bus.IDrt));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_stall         = 1'b0;
    w_flush         = 1'b0;
    w_flush_entry   = 1'b0;
    if (!clrn) begin
      unique case (r_state)
        ST_RUN, ST_LDSTALL: begin
          if (bus.EXbr_taken) begin
            w_flush       = 1'b1;
            w_flush_entry = 1'b1;
            if (FLUSH_CYC > 1) begin
              w_state_nxt     = ST_FLUSH;
              w_remaining_nxt = FLUSH_LOAD;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else if (r_state == ST_RUN && w_ld_use) begin
            // Stall only from RUN: the re-presented instruction never stalls twice.
            w_stall     = 1'b1;
            w_state_nxt = ST_LDSTALL;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          w_flush         = 1'b1;
          w_remaining_nxt = r_remaining - 3'd1;
          if (w_remaining_nxt == 3'd0) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (clrn) begin
      r_state     <= ST_RUN;
      r_remaining <= 3'd0;
      r_ex        <= '0;
      r_mem       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_mem       <= r_ex;
      r_ex        <= '{valid: bus.IDvalid && !w_stall && !w_flush,
                       wreg:  bus.IDwreg,
                       m2reg: bus.IDm2reg,
                       wn:    bus.IDwn};
      if (w_stall && r_stall_cnt != '1)       r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_entry && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall     = w_stall;
  assign bus.flush     = w_flush;
  assign bus.fwda      = clrn ? 2'b00 : w_fwda;
  assign bus.fwdb      = clrn ? 2'b00 : w_fwdb;
  assign bus.state     = clrn ? 2'b00 : r_state;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int FLUSH_CYC = 2;

  logic clk = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  pipe_hazard_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) u_dut (.clk(clk), .clrn(clrn), .bus(bus));
  pipe_hazard_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(2))  u_sat (.clk(clk), .clrn(clrn), .bus(bus2));

  assign bus2.IDvalid    = bus.IDvalid;
  assign bus2.IDrs       = bus.IDrs;
  assign bus2.IDrt       = bus.IDrt;
  assign bus2.IDuse_rs   = bus.IDuse_rs;
  assign bus2.IDuse_rt   = bus.IDuse_rt;
  assign bus2.IDwreg     = bus.IDwreg;
  assign bus2.IDm2reg    = bus.IDm2reg;
  assign bus2.IDwn       = bus.IDwn;
  assign bus2.EXbr_taken = bus.EXbr_taken;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       valid;
    bit       wreg;
    bit       m2reg;
    bit [4:0] wn;
  } instr_t;

  instr_t hist[$];            // hist[0] = instruction now in EX, hist[1] = in MEM
  int     m_flush_left = 0;   // forced flush cycles still owed after a branch
  bit     m_just_stalled = 0;
  int     m_stalls = 0, m_flushes = 0;
  bit     m_ok = 0;

  bit     p_valid = 0, p_rst, p_stall, p_flush_entry;
  int     p_flush_left;
  instr_t p_new;

  function automatic bit writer(input instr_t x, input logic [4:0] r);
    return x.valid && x.wreg && x.wn != 5'd0 && x.wn == r;
  endfunction

  function automatic logic [1:0] m_fwd(input logic use_r, input logic [4:0] r);
    if (!use_r) return 2'b00;
    for (int age = 0; age < 2; age++) begin
      if (writer(hist[age], r)) begin
        if (age == 1)             return hist[age].m2reg ? 2'b11 : 2'b10;
        if (!hist[age].m2reg)     return 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic int sat(input int c, input int w);
    int top;
    top = (1 << w) - 1;
    return (c > top) ? top : c;
  endfunction

  initial begin
    instr_t z;
    z = '{default: 0};
    hist.push_back(z);
    hist.push_back(z);
  end

  // Compare process: outputs vs model every cycle, then stage the model update.
  always @(negedge clk) begin
    bit in_flush, e_flush, e_stall, ld_use;
    logic [1:0] e_state;
    in_flush = m_flush_left > 0;
    ld_use   = bus.IDvalid && hist[0].m2reg &&
               ((bus.IDuse_rs && writer(hist[0], bus.IDrs)) ||
                (bus.IDuse_rt && writer(hist[0], bus.IDrt)));
    e_flush  = !clrn && (in_flush || bus.EXbr_taken);
    e_stall  = !clrn && !e_flush && !m_just_stalled && ld_use;
    e_state  = clrn ? 2'd0 : in_flush ? 2'd2 : m_just_stalled ? 2'd1 : 2'd0;
    if (m_ok) begin
      check("stall", bus.stall, e_stall);
      check("flush", bus.flush, e_flush);
      check("state", bus.state, e_state);
      if (!e_stall) begin
        check("fwda", bus.fwda, clrn ? 2'b00 : m_fwd(bus.IDuse_rs, bus.IDrs));
        check("fwdb", bus.fwdb, clrn ? 2'b00 : m_fwd(bus.IDuse_rt, bus.IDrt));
      end
      check("stall_cnt16", bus.stall_cnt,  sat(m_stalls, 16));
      check("flush_cnt16", bus.flush_cnt,  sat(m_flushes, 16));
      check("stall_cnt2",  bus2.stall_cnt, sat(m_stalls, 2));
      check("flush_cnt2",  bus2.flush_cnt, sat(m_flushes, 2));
      check("sat_stall",   bus2.stall,     e_stall);
    end
    p_rst         = clrn;
    p_stall       = e_stall;
    p_flush_entry = e_flush && !in_flush;
    p_flush_left  = in_flush ? m_flush_left - 1 : (e_flush ? FLUSH_CYC - 1 : 0);
    p_new         = '{valid: bus.IDvalid && !e_stall && !e_flush, wreg: bus.IDwreg,
                      m2reg: bus.IDm2reg, wn: bus.IDwn};
    p_valid       = 1;
  end

  always @(posedge clk) begin
    if (p_valid) begin
      if (p_rst) begin
        for (int i = 0; i < 2; i++) hist[i] = '{default: 0};
        m_flush_left   = 0;
        m_just_stalled = 0;
        m_stalls       = 0;
        m_flushes      = 0;
        m_ok           = 1;
      end else begin
        hist.push_front(p_new);
        void'(hist.pop_back());
        m_flush_left   = p_flush_left;
        m_just_stalled = p_stall;
        m_stalls      += int'(p_stall);
        m_flushes     += int'(p_flush_entry);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Applies one cycle of inputs just after the edge and returns mid-cycle.
  task automatic cyc(input logic c, input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic wr, input logic m2,
                     input logic [4:0] wn, input logic br);
    @(posedge clk); #1;
    clrn           = c;
    bus.IDvalid    = v;
    bus.IDrs       = rs;
    bus.IDuse_rs   = urs;
    bus.IDrt       = rt;
    bus.IDuse_rt   = urt;
    bus.IDwreg     = wr;
    bus.IDm2reg    = m2;
    bus.IDwn       = wn;
    bus.EXbr_taken = br;
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IDvalid = 0; bus.IDrs = 0; bus.IDrt = 0; bus.IDuse_rs = 0; bus.IDuse_rt = 0;
    bus.IDwreg = 0; bus.IDm2reg = 0; bus.IDwn = 0; bus.EXbr_taken = 0;
    repeat (2) @(posedge clk);

    //   c  v  rs    urs rt    urt wr m2 wn    br
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);          // idle after reset
    check("rst_state", bus.state, 2'b00);
    check("rst_scnt", bus.stall_cnt, 16'd0);
    check("rst_fcnt", bus.flush_cnt, 16'd0);

    cyc(0, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd3, 0);          // add r3
    cyc(0, 1, 5'd3, 1, 5'd0, 0, 1, 0, 5'd4, 0);          // sub r4, r3
    check("alu_ex_fwda", bus.fwda, 2'b01);
    check("alu_ex_stall", bus.stall, 1'b0);
    cyc(0, 1, 5'd3, 1, 5'd7, 1, 0, 0, 5'd0, 0);          // reads r3, r7
    check("alu_mem_fwda", bus.fwda, 2'b10);
    check("alu_mem_fwdb", bus.fwdb, 2'b00);

    cyc(0, 1, 5'd1, 1, 5'd0, 0, 1, 1, 5'd5, 0);          // lw r5
    cyc(0, 1, 5'd2, 1, 5'd5, 1, 1, 0, 5'd6, 0);          // add r6, r2, r5
    check("lu_stall", bus.stall, 1'b1);
    check("lu_state_run", bus.state, 2'b00);
    cyc(0, 1, 5'd2, 1, 5'd5, 1, 1, 0, 5'd6, 0);          // re-presented
    check("lu_fwdb", bus.fwdb, 2'b11);
    check("lu_restall", bus.stall, 1'b0);
    check("lu_state", bus.state, 2'b01);
    check("lu_scnt", bus.stall_cnt, 16'd1);

    cyc(0, 1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0);          // lw r0
    cyc(0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 5'd0, 0);          // reads r0
    check("r0_fwda", bus.fwda, 2'b00);
    check("r0_stall", bus.stall, 1'b0);
    check("r0_state", bus.state, 2'b00);

    cyc(0, 1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0);          // lw r9
    cyc(0, 1, 5'd9, 1, 5'd0, 0, 1, 0, 5'd8, 1);          // load-use plus taken branch
    check("br_flush", bus.flush, 1'b1);
    check("br_stall", bus.stall, 1'b0);
    cyc(0, 1, 5'd9, 1, 5'd0, 0, 1, 0, 5'd8, 1);          // branch again, ignored
    check("br_flush2", bus.flush, 1'b1);
    check("br_state", bus.state, 2'b10);
    check("br_fcnt", bus.flush_cnt, 16'd1);
    check("br_scnt", bus.stall_cnt, 16'd1);
    cyc(0, 1, 5'd9, 1, 5'd0, 0, 1, 0, 5'd8, 0);
    check("br_done", bus.flush, 1'b0);
    check("br_fcnt_hold", bus.flush_cnt, 16'd1);

    cyc(0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1);          // enter FLUSH
    cyc(1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1);          // reset mid-flush
    check("rstf_flush", bus.flush, 1'b0);
    check("rstf_state", bus.state, 2'b00);
    cyc(0, 1, 5'd9, 1, 5'd9, 1, 0, 0, 5'd0, 0);
    check("rstf_after_state", bus.state, 2'b00);
    check("rstf_after_fwda", bus.fwda, 2'b00);
    check("rstf_scnt", bus.stall_cnt, 16'd0);
    check("rstf_fcnt", bus.flush_cnt, 16'd0);

    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd5, 0);        // lw r5
      cyc(0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 5'd0, 0);        // uses r5
      check("sat_loop_stall", bus.stall, 1'b1);
      cyc(0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 5'd0, 0);        // re-presented
    end
    check("sat_cnt2", bus2.stall_cnt, 2'd3);
    check("sat_cnt16", bus.stall_cnt, 16'd5);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 7) != 0,
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          5'($urandom_range(0, 7)),
          $urandom_range(0, 9) == 0);
    end
    cyc(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
